iter_div_unit: RTL and testbench

//  Multi-cycle restoring radix-2 divider: responder side of the start/ready handshake the EX-stage ALU top drives.

---
 rtl/iter_div_if.sv | 23 ++
 rtl/iter_div_unit.sv | 132 +++++++++++++
 tb/tb_iter_div_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/iter_div_if.sv
// Start/ready handshake bundle between the EX-stage ALU top (master) and the
// iterative divider (slave).
interface iter_div_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/iter_div_unit.sv
// Multi-cycle restoring radix-2 divider returning {remainder, quotient}.
// Optional DIV_EARLY_EXIT_EN: skip iterations when |dividend| < |divisor|.
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       annul_i,
  iter_div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   divd_q, divd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               abort;
  logic               a_neg, b_neg, early_exit, no_borrow, last_iter;
  logic [WIDTH-1:0]   a_abs, b_abs, rem_next, quo_next, q_fix, r_fix;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;

  assign abort = flush | annul_i;

  assign a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign a_abs = a_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign b_abs = b_neg ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (a_abs < b_abs);
`else
  assign early_exit = 1'b0;
`endif

  // One restoring step: the extra top bit of diff is the borrow.
  assign shifted   = {rem_q, divd_q[WIDTH-1]};
  assign diff      = {1'b0, shifted} - {2'b00, dvsr_q};
  assign no_borrow = ~diff[WIDTH+1];
  assign rem_next  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next  = {divd_q[WIDTH-2:0], no_borrow};
  assign q_fix     = negq_q ? -quo_next : quo_next;
  assign r_fix     = negr_q ? -rem_next : rem_next;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    divd_d   = divd_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !abort) begin
          if (bus.opdata2_i == '0) begin
            result_d = {bus.opdata1_i, {WIDTH{1'b1}}};
            state_d  = S_DONE;
          end else if (early_exit) begin
            result_d = {bus.opdata1_i, {WIDTH{1'b0}}};
            state_d  = S_DONE;
          end else begin
            divd_d  = a_abs;
            dvsr_d  = b_abs;
            rem_d   = '0;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d  = rem_next;
        divd_d = quo_next;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = {r_fix, q_fix};
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything; the previous result stays visible.
    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      divd_q   <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      divd_q   <= divd_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q == S_CALC);
  assign bus.ready_o  = (state_q == S_DONE);
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic division model.
module tb_iter_div_unit;
  logic clk = 1'b0;
  logic rst, flush, annul_i;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [63:0] last_result;

  always #5 clk = ~clk;

  iter_div_if #(.WIDTH(32)) bus ();

  iter_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .annul_i(annul_i),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero and keeps the
  // remainder's sign equal to the dividend's, which is exactly DIV/DIVU.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 1;
`endif
    return (ma == mb) ? 33 : 33;
  endfunction

  task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit wiggle);
    logic [63:0] exp;
    int exp_lat, lat;
    bit seen;
    exp     = ref_div(sgn, a, b);
    exp_lat = ref_lat(sgn, a, b);
    @(negedge clk);
    check({tag, "_pre_ready"}, {63'd0, bus.ready_o}, 64'd0);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, "_busy1"}, {63'd0, bus.busy_o}, {63'd0, exp_lat > 1});
      if (bus.ready_o) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
      if (wiggle) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = $urandom_range(0, 1);
      end
    end
    bus.start_i = 1'b0;
    check({tag, "_ready_seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy_at_ready"}, {63'd0, bus.busy_o}, 64'd0);
      check({tag, "_result"}, bus.result_o, exp);
      last_result = exp;
    end
  endtask

  task automatic abort_test(input string tag, input bit use_annul);
    int readies;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    check({tag, "_busy_mid"}, {63'd0, bus.busy_o}, 64'd1);
    if (use_annul) annul_i = 1'b1; else flush = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    annul_i     = 1'b0;
    bus.start_i = 1'b0;
    check({tag, "_busy_after"}, {63'd0, bus.busy_o}, 64'd0);
    readies = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.ready_o) readies++;
      @(negedge clk);
    end
    check({tag, "_no_ready"}, 64'(readies), 64'd0);
    check({tag, "_result_kept"}, bus.result_o, last_result);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    rst = 1'b1; flush = 1'b0; annul_i = 1'b0;
    bus.start_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    last_result = 64'd0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 1'b1, -32'sd7, 32'd2, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, -32'sd2, 1'b0);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    run_op("div_by0", 1'b1, 32'h8765_4321, 32'd0, 1'b0);
    run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 1'b0);
    run_op("div_m3_10", 1'b1, -32'sd3, 32'd10, 1'b0);
    run_op("divu_wiggle", 1'b0, 32'hDEAD_BEEF, 32'd13, 1'b1);

    abort_test("flush", 1'b0);
    run_op("after_flush_9_3", 1'b0, 32'd9, 32'd3, 1'b0);
    abort_test("annul", 1'b1);
    run_op("after_annul", 1'b1, -32'sd100, 32'd9, 1'b0);

    // Flush coincident with start: nothing is accepted, even a zero-divisor op.
    @(negedge clk);
    bus.opdata1_i = 32'h5555_AAAA; bus.opdata2_i = 32'd0; bus.start_i = 1'b1; flush = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, bus.busy_o}, 64'd0);
    @(negedge clk);
    check("flush_start_ready", {63'd0, bus.ready_o}, 64'd0);
    check("flush_start_result", bus.result_o, last_result);

    // Reset in the middle of a calculation.
    @(negedge clk);
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start_i = 1'b0;
    check("midrst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    last_result = 64'd0;

    for (int i = 0; i < 60; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 255);
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), rs, ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
